fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning width of the FIFO read data and the stream data.
REQ-002 SHALL have parameter BURST_LEN, default 16, meaning beats per burst; m_last_o marks the final beat; legal range 1..256.
REQ-003 SHALL have port rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fifo_empty_i  input  1  empty flag from the async FIFO read side.
REQ-006 SHALL have port fifo_rdata_i  input  DATA_LEN  FIFO read data, valid one cycle after an accepted read.
REQ-007 SHALL have port fifo_rd_en_o  output  1  read strobe to the FIFO.
REQ-008 SHALL have port flush_i  input  1  discard buffered/in-flight words and restart burst count.
REQ-009 SHALL have port m_valid_o  output  1  stream word valid.
REQ-010 SHALL have port m_ready_i  input  1  downstream accepts word.
REQ-011 SHALL have port m_data_o  output  DATA_LEN  stream data.
REQ-012 SHALL have port m_last_o  output  1  last beat of current burst.
REQ-013 SHALL have port stat_words_o  output  32  accepted-beat counter (see REQ-030).
REQ-014 SHALL have port stat_stall_o  output  32  starved-cycle counter (see REQ-030).

Function
REQ-015 SHALL hold a 3-entry in-order skid buffer plus a 1-bit in-flight flag for a read issued in the previous cycle.
REQ-016 SHALL drive fifo_rd_en_o=1 iff !fifo_empty_i && !flush_i && !rst && (occupancy + inflight) < 3; no combinational path from m_ready_i to fifo_rd_en_o.
REQ-017 SHALL treat a cycle with fifo_rd_en_o=1 as an accepted read; fifo_rdata_i sampled on the following rising edge is written to the buffer tail.
REQ-018 SHALL drive m_valid_o=1 iff occupancy != 0; m_data_o = buffer head, registered, no combinational path from fifo_rdata_i.
REQ-019 SHALL treat m_valid_o && m_ready_i as a handshake; head popped at that edge.
REQ-020 SHALL keep m_data_o and m_last_o stable while m_valid_o=1 && m_ready_i=0.
REQ-021 SHALL allow push and pop in the same cycle; occupancy unchanged, order preserved.
REQ-022 SHALL sustain one beat per cycle when FIFO non-empty and m_ready_i held high; first m_valid_o two cycles after fifo_empty_i falls with buffer empty.
REQ-023 SHALL keep a beat counter 0..BURST_LEN-1; m_last_o = m_valid_o && (beat == BURST_LEN-1); increment on handshake, wrap to 0 after last beat; BURST_LEN=1 gives m_last_o on every beat.
REQ-024 SHALL on flush_i=1: clear occupancy, m_valid_o=0 next cycle, beat counter to 0, discard any in-flight word arriving the next cycle; a handshake in the flush cycle is still counted by stats.
REQ-025 SHALL never overflow the buffer; occupancy > 3 is a design error.

Reset
REQ-026 SHALL on rst=1 at a rising edge clear occupancy, inflight, beat counter, stats counters.
REQ-027 SHALL drive during and after reset: fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, stat_words_o=0, stat_stall_o=0.
REQ-028 SHALL on reset mid-stream drop buffered and in-flight words; FIFO words already read are lost.

Configuration
REQ-029 SHALL use macro FIFO_RD_STREAM_STATS_EN to compile in the statistics counters.
REQ-030 SHALL with the macro defined: stat_words_o increments per handshake; stat_stall_o increments per cycle with m_ready_i=1 && m_valid_o=0; both saturate at 32'hFFFF_FFFF; without it: both ports tied to 0, no counter flops.

Verification
REQ-031 SHALL cover: 40 words 0..39 in FIFO, m_ready_i=1 constant -> 40 consecutive beats, m_last_o on words 15 and 31, no gaps after first beat.
REQ-032 SHALL cover: m_ready_i low 5 cycles with 3 buffered -> fifo_rd_en_o stays 0, m_data_o stable; on release, order 0,1,2,3 intact.
REQ-033 SHALL cover: fifo_empty_i toggling every other cycle, random m_ready_i -> no loss, no duplication over 1000 words.
REQ-034 SHALL cover: flush_i at beat 7 with 2 buffered and 1 in flight -> next m_valid_o word is fresh FIFO data, m_last_o at 16th beat after flush.
REQ-035 SHALL cover: rst asserted mid-burst -> all outputs 0 next cycle, beat counter restarts at 0.
REQ-036 SHALL cover with FIFO_RD_STREAM_STATS_EN: 20 handshakes plus 4 starved ready cycles -> stat_words_o=20, stat_stall_o=4; without macro -> both 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read side to valid/ready burst stream (stats via FIFO_RD_STREAM_STATS_EN)
module fifo_rd_stream #(
  parameter int DATA_LEN  = 32,
  parameter int BURST_LEN = 16
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                fifo_empty_i,
  input  logic [DATA_LEN-1:0] fifo_rdata_i,
  output logic                fifo_rd_en_o,
  input  logic                flush_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_LEN-1:0] m_data_o,
  output logic                m_last_o,
  output logic [31:0]         stat_words_o,
  output logic [31:0]         stat_stall_o
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [DATA_LEN-1:0] buf_mem [3];
  logic [1:0]          head;
  logic [1:0]          tail;
  logic [1:0]          occ;
  logic                inflight;
  logic [BW-1:0]       beat;
  logic                push;
  logic                pop;
  logic                valid_int;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are only issued when the buffer has room for everything already requested,
  // so the word returning from the FIFO always has a free slot.
  assign fifo_rd_en_o = !fifo_empty_i && !flush_i && !rst &&
                        (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  // A word requested last cycle is on fifo_rdata_i now; a flush throws it away.
  assign push      = inflight && !flush_i;
  assign valid_int = (occ != 2'd0) && !rst;
  assign pop       = valid_int && m_ready_i;

  assign m_valid_o = valid_int;
  assign m_data_o  = valid_int ? buf_mem[head] : '0;
  assign m_last_o  = valid_int && (beat == LAST_BEAT);

  // Buffer control: pointers, occupancy, in-flight flag and burst beat counter.
  always_ff @(posedge rclk) begin
    if (rst || flush_i) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= fifo_rd_en_o;
      if (push) tail <= next_ptr(tail);
      if (pop) begin
        head <= next_ptr(head);
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge rclk) begin
    if (!rst && push) buf_mem[tail] <= fifo_rdata_i;
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stall_q;

  // Saturating counters of accepted beats and of cycles where downstream waited on us.
  always_ff @(posedge rclk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      if (m_ready_i && !valid_int && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_words_o = rst ? 32'd0 : words_q;
  assign stat_stall_o = rst ? 32'd0 : stall_q;
`else
  assign stat_words_o = 32'd0;
  assign stat_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int BL = 16;

  logic        rclk = 1'b0;
  logic        rst;
  logic        fifo_empty_i;
  logic [31:0] fifo_rdata_i;
  logic        fifo_rd_en_o;
  logic        flush_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        m_last_o;
  logic [31:0] stat_words_o;
  logic [31:0] stat_stall_o;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_LEN(32), .BURST_LEN(BL)) dut (
    .rclk(rclk), .rst(rst), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_rd_en_o(fifo_rd_en_o), .flush_i(flush_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .stat_words_o(stat_words_o), .stat_stall_o(stat_stall_o)
  );

  typedef struct {
    logic [31:0] d;
    int          t;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  ent_t        exp_q[$];
  logic [31:0] fifo_q[$];
  bit          force_empty;
  int          beats;
  logic [31:0] m_words;
  logic [31:0] m_stall;
  logic [31:0] hs_data[$];
  bit          hs_last[$];
  int          hs_cyc[$];
  int          first_valid_cyc;
  logic        s_valid, s_rd, s_last;
  logic [31:0] s_data, s_words, s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare DUT against the model, advance the model, emulate the FIFO.
  task automatic cycle();
    bit          er, ev, el, hs, rd_now;
    logic [31:0] ed, ew, es, word;
    fifo_empty_i = (fifo_q.size() == 0) || force_empty;
    #1;
    s_valid = m_valid_o; s_rd = fifo_rd_en_o; s_last = m_last_o;
    s_data = m_data_o; s_words = stat_words_o; s_stall = stat_stall_o;
    er = !fifo_empty_i && !flush_i && !rst && (exp_q.size() < 3);
    ev = !rst && (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
    ed = ev ? exp_q[0].d : 32'd0;
    el = ev && ((beats % BL) == BL - 1);
`ifdef FIFO_RD_STREAM_STATS_EN
    ew = rst ? 32'd0 : m_words;
    es = rst ? 32'd0 : m_stall;
`else
    ew = 32'd0;
    es = 32'd0;
`endif
    chk("rd_en", {31'd0, s_rd}, {31'd0, er});
    chk("m_valid", {31'd0, s_valid}, {31'd0, ev});
    chk("m_data", s_data, ed);
    chk("m_last", {31'd0, s_last}, {31'd0, el});
    chk("stat_words", s_words, ew);
    chk("stat_stall", s_stall, es);
    if (ev && first_valid_cyc < 0) first_valid_cyc = cyc;
    hs = ev && m_ready_i;
    if (rst) begin
      exp_q.delete();
      beats = 0; m_words = 0; m_stall = 0;
    end else begin
      if (hs) begin
        hs_data.push_back(ed); hs_last.push_back(el); hs_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        beats = (beats + 1) % BL;
        if (m_words != 32'hFFFF_FFFF) m_words++;
      end
      if (m_ready_i && !ev && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush_i) begin
        exp_q.delete();
        beats = 0;
      end
    end
    rd_now = s_rd && (fifo_q.size() > 0);
    word = 32'd0;
    if (rd_now) begin
      word = fifo_q.pop_front();
      exp_q.push_back('{word, cyc});
    end
    @(posedge rclk);
    @(negedge rclk);
    fifo_rdata_i = rd_now ? word : (32'hBAD0_0000 ^ 32'(cyc));
    cyc++;
  endtask

  task automatic clear_log();
    hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    first_valid_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; m_ready_i = 1'b0; force_empty = 1'b0;
    fifo_q.delete();
    cycle(); cycle();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    int t0, n_last, bad, idx;
    logic [31:0] la[$];
    rst = 1'b1; flush_i = 1'b0; m_ready_i = 1'b0; force_empty = 1'b0;
    fifo_rdata_i = 32'd0; fifo_empty_i = 1'b1;
    beats = 0; m_words = 0; m_stall = 0; first_valid_cyc = -1;

    // Reset state
    do_reset();
    chk("reset_valid", {31'd0, s_valid}, 32'd0);
    chk("reset_rd_en", {31'd0, s_rd}, 32'd0);
    chk("reset_data", s_data, 32'd0);
    chk("reset_words", s_words, 32'd0);

    // 40 words with ready held high
    for (int i = 0; i < 40; i++) fifo_q.push_back(32'(i));
    m_ready_i = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100 && hs_data.size() < 40; k++) cycle();
    chk("s1_count", hs_data.size(), 40);
    chk("s1_first_latency", 32'(first_valid_cyc - t0), 32'd2);
    chk("s1_no_gap", 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 32'd39);
    bad = 0; la.delete();
    foreach (hs_data[i]) begin
      if (hs_data[i] != 32'(i)) bad++;
      if (hs_last[i]) la.push_back(hs_data[i]);
    end
    chk("s1_order", bad, 0);
    chk("s1_last_count", la.size(), 2);
    chk("s1_last_a", (la.size() > 0) ? la[0] : 32'hFFFF_FFFF, 32'd15);
    chk("s1_last_b", (la.size() > 1) ? la[1] : 32'hFFFF_FFFF, 32'd31);

    // Backpressure with three words buffered
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'(i));
    repeat (5) cycle();
    chk("s2_pending", exp_q.size(), 3);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("s2_rd_hold", {31'd0, s_rd}, 32'd0);
      chk("s2_valid_hold", {31'd0, s_valid}, 32'd1);
      chk("s2_data_hold", s_data, 32'd0);
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 20 && hs_data.size() < 4; k++) cycle();
    chk("s2_count", hs_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("s2_order", hs_data[i], 32'(i));

    // Toggling empty flag, random ready, 1000 words
    do_reset();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(32'(1000 + i));
    for (int k = 0; k < 12000 && hs_data.size() < 1000; k++) begin
      force_empty = ~force_empty;
      m_ready_i = 1'($urandom_range(0, 1));
      cycle();
    end
    force_empty = 1'b0;
    m_ready_i = 1'b0;
    chk("s3_count", hs_data.size(), 1000);
    bad = 0;
    foreach (hs_data[i]) if (hs_data[i] != 32'(1000 + i)) bad++;
    chk("s3_order", bad, 0);

    // Flush at beat 7 with two buffered and one in flight
    do_reset();
    for (int i = 0; i < 60; i++) fifo_q.push_back(32'(200 + i));
    m_ready_i = 1'b1;
    for (int k = 0; k < 50 && hs_data.size() < 7; k++) cycle();
    m_ready_i = 1'b0;
    cycle();
    chk("s4_pending", exp_q.size(), 3);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    clear_log();
    m_ready_i = 1'b1;
    for (int k = 0; k < 60 && hs_data.size() < 16; k++) cycle();
    chk("s4_fresh", hs_data[0], 32'd210);
    idx = -1;
    foreach (hs_last[i]) if (hs_last[i] && idx < 0) idx = i;
    chk("s4_last_idx", 32'(idx), 32'd15);
    chk("s4_last_data", hs_data[15], 32'd225);

    // Reset mid-burst
    do_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back(32'(500 + i));
    m_ready_i = 1'b1;
    for (int k = 0; k < 50 && hs_data.size() < 5; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_log();
    cycle();
    chk("s5_valid", {31'd0, s_valid}, 32'd0);
    chk("s5_data", s_data, 32'd0);
    chk("s5_last", {31'd0, s_last}, 32'd0);
    chk("s5_words", s_words, 32'd0);
    for (int k = 0; k < 60 && hs_data.size() < 16; k++) cycle();
    chk("s5_fresh", hs_data[0], 32'd507);
    idx = -1;
    foreach (hs_last[i]) if (hs_last[i] && idx < 0) idx = i;
    chk("s5_last_idx", 32'(idx), 32'd15);

    // Statistics: 20 handshakes then 4 starved ready cycles
    do_reset();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'(900 + i));
    repeat (6) cycle();
    m_ready_i = 1'b1;
    repeat (24) cycle();
    m_ready_i = 1'b0;
    cycle();
    chk("s6_hs", hs_data.size(), 20);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("s6_words", s_words, 32'd20);
    chk("s6_stall", s_stall, 32'd4);
`else
    chk("s6_words", s_words, 32'd0);
    chk("s6_stall", s_stall, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
